ps2_frame_receiver: RTL

Upstream PS/2 device-to-host receiver. It samples the raw PS/2 clock and data lines, deserialises 11-bit frames (start, 8 data bits LSB first, odd parity, stop), and validates each frame. Each valid byte is held in a one-entry buffer, with a receive flag, until the downstream Set-2→Set-1 converter clears it. The block sits between the keyboard pins and the scancode converter.

---
 rtl/ps2_frame_receiver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver.
// Synchronises and deglitches the raw PS/2 lines, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and holds each good byte in a
// one-entry buffer until the downstream converter clears it.
module ps2_frame_receiver #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       recive_flag,
  input  logic       clear_keycode,
  output logic       frame_error,
  output logic       overrun
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          recive_flag_q, recive_flag_d;
  logic          frame_error_q, frame_error_d;
  logic          overrun_q, overrun_d;
  logic          fall;
  logic          frame_ok;

  // Next-state logic: synchronisers, clock filter, frame FSM and byte buffer.
  always_comb begin
    clk_s1_d      = ps2_clock;
    clk_s2_d      = clk_s1_q;
    dat_s1_d      = ps2_data;
    dat_s2_d      = dat_s1_q;
    filt_clk_d    = filt_clk_q;
    filt_cnt_d    = '0;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    tmo_cnt_d     = tmo_cnt_q;
    keycode_d     = keycode_q;
    recive_flag_d = recive_flag_q;
    frame_error_d = 1'b0;
    overrun_d     = overrun_q;
    fall          = 1'b0;
    frame_ok      = 1'b0;

    // Filtered clock flips only after FILTER_CYCLES differing samples in a row.
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
        fall       = filt_clk_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end

    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
      if (fall && !dat_s2_q) begin
        state_d   = S_DATA;
        bit_cnt_d = 3'd0;
      end
    end else if (fall) begin
      tmo_cnt_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && ((^shift_q) ^ parity_q)) frame_ok = 1'b1;
          else                                       frame_error_d = 1'b1;
        end
        default: ;
      endcase
    end else if (tmo_cnt_q == TMO_LAST) begin
      // Line went quiet mid-frame: abandon the partial byte.
      state_d       = S_IDLE;
      tmo_cnt_d     = '0;
      shift_d       = '0;
      frame_error_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    // Clear is applied before a completing frame is considered, so a byte
    // finishing in the clear cycle is loaded rather than counted as overrun.
    if (clear_keycode) begin
      recive_flag_d = 1'b0;
      overrun_d     = 1'b0;
    end
    if (frame_ok) begin
      if (recive_flag_d) begin
        overrun_d = 1'b1;
      end else begin
        keycode_d     = shift_q;
        recive_flag_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      filt_clk_q    <= 1'b1;
      filt_cnt_q    <= '0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      keycode_q     <= 8'h00;
      recive_flag_q <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      clk_s1_q      <= clk_s1_d;
      clk_s2_q      <= clk_s2_d;
      dat_s1_q      <= dat_s1_d;
      dat_s2_q      <= dat_s2_d;
      filt_clk_q    <= filt_clk_d;
      filt_cnt_q    <= filt_cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      keycode_q     <= keycode_d;
      recive_flag_q <= recive_flag_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  assign keycode     = keycode_q;
  assign recive_flag = recive_flag_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule
